// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between the FIFO-side reader and its stream sink.
// master modport is the reader; slave is the surrounding FIFO/sink environment.
interface fifo_stream_reader_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
);
  logic              en;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_rdata;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              busy;
  logic [CNT_W-1:0]  word_cnt;

  modport master (
    input  en, fifo_empty, fifo_rdata, m_ready,
    output fifo_rd_en, m_valid, m_data, busy, word_cnt
  );

  modport slave (
    output en, fifo_empty, fifo_rdata, m_ready,
    input  fifo_rd_en, m_valid, m_data, busy, word_cnt
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Pops a one-cycle-latency FIFO and re-presents its words on a valid/ready stream
// through a 2-entry skid buffer, keeping full throughput under a credit rule.
module fifo_stream_reader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_stream_reader_if.master bus
);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [1:0]        occ_q, occ_d;
  logic              inflight_q;
  logic              m_valid_q;
  logic              busy_q;
  logic [CNT_W-1:0]  word_cnt_q;
  logic              pop_c;
  logic              rd_en_c;
  logic [2:0]        credit_c;

  // Buffered words plus the in-flight word, less the one leaving this cycle.
  assign pop_c    = m_valid_q && bus.m_ready;
  assign credit_c = 3'(occ_q) + 3'(inflight_q) - 3'(pop_c);
  assign rd_en_c  = bus.en && !bus.fifo_empty && !rst && (credit_c < 3'd2);

  assign bus.fifo_rd_en = rd_en_c;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = head_q;
  assign bus.busy       = busy_q;
  assign bus.word_cnt   = word_cnt_q;

  // Buffer update: capture lands behind whatever survives this cycle's pop.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    unique case ({inflight_q, pop_c})
      2'b11: begin
        if (occ_q == 2'd2) begin
          head_d = tail_q;
          tail_d = bus.fifo_rdata;
        end else begin
          head_d = bus.fifo_rdata;
        end
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_d = bus.fifo_rdata;
        end else begin
          tail_d = bus.fifo_rdata;
        end
        occ_d = occ_q + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      m_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= rd_en_c;
      m_valid_q  <= (occ_d != 2'd0);
      busy_q     <= rd_en_c || (occ_d != 2'd0);
      if (pop_c) begin
        word_cnt_q <= word_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
